card_deal_ctrl: RTL and testbench

Sequences dealing for the 9-slot card display chain (slots 0..8, left to right).
- Accepts one deal request at a time from the game state machine.
- Pulls a 6-bit card code from the deck source over a valid/ready handshake and stores it in the next free slot.
- Holds the slot hidden for a frame-counted reveal delay, then makes it visible.
- Maintains the hand total with soft-ace handling, plus bust and blackjack flags, for the game state machine.

---
 rtl/card_pkg.sv | 39 +++
 rtl/card_deal_ctrl_hand_value_calc.sv | 71 +++++++
 rtl/card_deal_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_card_deal_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types, constants and card-value helpers for the card dealing
// controller and its hand-total calculator.
package card_pkg;

  localparam int NUM_SLOTS_DEFAULT = 9;
  localparam int BJ_TARGET         = 21;
  localparam int ACE_BONUS         = 10;

  typedef logic [5:0] card_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REVEAL,
    ST_ACK
  } deal_state_t;

  // Point value of a card; codes beyond the 52-card deck count as 10.
  function automatic logic [3:0] card_value(input card_code_t code);
    logic [3:0] rank;
    if (code > 6'd51) begin
      return 4'd10;
    end
    rank = 4'(code % 6'd13);
    if (rank == 4'd0) begin
      return 4'd1;
    end else if (rank <= 4'd8) begin
      return rank + 4'd1;
    end else begin
      return 4'd10;
    end
  endfunction

  // True only for genuine aces; out-of-deck codes are never aces.
  function automatic logic is_ace(input card_code_t code);
    return (code <= 6'd51) && ((code % 6'd13) == 6'd0);
  endfunction

endpackage

// File: rtl/card_deal_ctrl_hand_value_calc.sv
// hand_value_calc: registered hand total (soft-ace aware), bust and
// blackjack flags computed from slot codes and the visible-slot mask.
// Results appear one cycle after the mask or codes change.
module hand_value_calc
  import card_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6*NUM_SLOTS-1:0] slot_cards,
  input  logic [NUM_SLOTS-1:0]   visible,
  output logic [4:0]             hand_total,
  output logic                   bust,
  output logic                   blackjack
);

  localparam int VC_W = $clog2(NUM_SLOTS + 1);

  logic [6:0]           slot_val [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_ace;

  logic [6:0]      hard_sum;
  logic [6:0]      best_sum;
  logic [VC_W-1:0] vis_cnt;

  logic [4:0] hand_total_d, hand_total_q;
  logic       bust_d, bust_q;
  logic       blackjack_d, blackjack_q;

  // Per-slot value and ace flag, masked by visibility.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign slot_val[gi] = visible[gi] ? 7'(card_value(slot_cards[6*gi +: 6])) : 7'd0;
    assign slot_ace[gi] = visible[gi] & is_ace(slot_cards[6*gi +: 6]);
  end

  // Sum visible values, promote one ace to 11 when it does not bust.
  always_comb begin
    hard_sum = 7'd0;
    vis_cnt  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hard_sum = hard_sum + slot_val[i];
      vis_cnt  = vis_cnt + VC_W'(visible[i]);
    end
    best_sum = hard_sum;
    if ((|slot_ace) && ((hard_sum + 7'(ACE_BONUS)) <= 7'(BJ_TARGET))) begin
      best_sum = hard_sum + 7'(ACE_BONUS);
    end
    hand_total_d = (best_sum > 7'd31) ? 5'd31 : best_sum[4:0];
    bust_d       = hard_sum > 7'(BJ_TARGET);
    blackjack_d  = (vis_cnt == VC_W'(2)) && (best_sum == 7'(BJ_TARGET));
  end

  // Register the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      hand_total_q <= 5'd0;
      bust_q       <= 1'b0;
      blackjack_q  <= 1'b0;
    end else begin
      hand_total_q <= hand_total_d;
      bust_q       <= bust_d;
      blackjack_q  <= blackjack_d;
    end
  end

  assign hand_total = hand_total_q;
  assign bust       = bust_q;
  assign blackjack  = blackjack_q;

endmodule

// File: rtl/card_deal_ctrl.sv
// card_deal_ctrl: sequences one deal at a time into the 9-slot display
// chain: fetch a card over valid/ready, store it, wait a frame-counted
// reveal delay, make the slot visible, then acknowledge.
// Optional macro CARD_DEAL_HOLE_EN adds a hidden hole-card slot
// (HOLE_SLOT) that is only shown after a reveal_hole pulse.
module card_deal_ctrl
  import card_pkg::*;
#(
  parameter int NUM_SLOTS     = NUM_SLOTS_DEFAULT,
  parameter int REVEAL_FRAMES = 8,
  parameter int CNT_W         = 4
`ifdef CARD_DEAL_HOLE_EN
  , parameter int HOLE_SLOT   = 1
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   deal_req,
  input  logic                   clear,
  input  logic                   card_valid,
  input  logic [5:0]             card_code,
`ifdef CARD_DEAL_HOLE_EN
  input  logic                   reveal_hole,
`endif
  output logic                   card_ready,
  output logic                   deal_ack,
  output logic                   deal_err,
  output logic                   busy,
  output logic [CNT_W-1:0]       card_count,
  output logic [NUM_SLOTS-1:0]   slot_visible,
  output logic [6*NUM_SLOTS-1:0] slot_cards,
  output logic [4:0]             hand_total,
  output logic                   bust,
  output logic                   blackjack
);

  localparam int FC_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = (REVEAL_FRAMES > 0) ? FC_W'(REVEAL_FRAMES - 1) : '0;

  deal_state_t          state_d, state_q;
  logic [CNT_W-1:0]     card_count_d, card_count_q;
  card_code_t           slot_d [NUM_SLOTS];
  card_code_t           slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_visible_d, slot_visible_q;
  logic [FC_W-1:0]      frame_cnt_d, frame_cnt_q;
  logic                 card_ready_d, card_ready_q;
  logic                 deal_ack_d, deal_ack_q;
  logic                 deal_err_d, deal_err_q;

  logic [CNT_W-1:0]     cur_slot;
  logic                 reveal_now;

  // Slot being revealed is the one most recently filled.
  assign cur_slot = card_count_q - CNT_W'(1);

  // Next-state and datapath updates; clear overrides everything.
  always_comb begin
    state_d        = state_q;
    card_count_d   = card_count_q;
    slot_d         = slot_q;
    slot_visible_d = slot_visible_q;
    frame_cnt_d    = frame_cnt_q;
    card_ready_d   = 1'b0;
    deal_ack_d     = 1'b0;
    deal_err_d     = 1'b0;
    reveal_now     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (deal_req) begin
          if (card_count_q < CNT_W'(NUM_SLOTS)) begin
            state_d      = ST_FETCH;
            card_ready_d = 1'b1;
          end else begin
            state_d    = ST_ACK;
            deal_ack_d = 1'b1;
            deal_err_d = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        card_ready_d = 1'b1;
        if (card_valid && card_ready_q) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (CNT_W'(i) == card_count_q) begin
              slot_d[i] = card_code;
            end
          end
          card_count_d = card_count_q + CNT_W'(1);
          frame_cnt_d  = '0;
          card_ready_d = 1'b0;
          state_d      = ST_REVEAL;
        end
      end

      ST_REVEAL: begin
        if (REVEAL_FRAMES == 0) begin
          reveal_now = 1'b1;
        end else if (frame_tick) begin
          if (frame_cnt_q == FC_LAST) begin
            reveal_now = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
        end
        if (reveal_now) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (CNT_W'(i) == cur_slot) begin
`ifdef CARD_DEAL_HOLE_EN
              if (i != HOLE_SLOT) begin
                slot_visible_d[i] = 1'b1;
              end
`else
              slot_visible_d[i] = 1'b1;
`endif
            end
          end
          state_d    = ST_ACK;
          deal_ack_d = 1'b1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef CARD_DEAL_HOLE_EN
    // Hole card shown on request once it has been dealt.
    if (reveal_hole && (card_count_q > CNT_W'(HOLE_SLOT))) begin
      slot_visible_d[HOLE_SLOT] = 1'b1;
    end
`endif

    if (clear) begin
      state_d        = ST_IDLE;
      card_count_d   = '0;
      slot_visible_d = '0;
      frame_cnt_d    = '0;
      card_ready_d   = 1'b0;
      deal_ack_d     = 1'b0;
      deal_err_d     = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_d[i] = '0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      card_count_q   <= '0;
      slot_visible_q <= '0;
      frame_cnt_q    <= '0;
      card_ready_q   <= 1'b0;
      deal_ack_q     <= 1'b0;
      deal_err_q     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      card_count_q   <= card_count_d;
      slot_visible_q <= slot_visible_d;
      frame_cnt_q    <= frame_cnt_d;
      card_ready_q   <= card_ready_d;
      deal_ack_q     <= deal_ack_d;
      deal_err_q     <= deal_err_d;
      slot_q         <= slot_d;
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_flat
    assign slot_cards[6*gi +: 6] = slot_q[gi];
  end

  assign card_ready   = card_ready_q;
  assign deal_ack     = deal_ack_q;
  assign deal_err     = deal_err_q;
  assign busy         = (state_q != ST_IDLE);
  assign card_count   = card_count_q;
  assign slot_visible = slot_visible_q;

  hand_value_calc #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_hand_value_calc (
    .clk        (clk),
    .rst        (rst),
    .slot_cards (slot_cards),
    .visible    (slot_visible_q),
    .hand_total (hand_total),
    .bust       (bust),
    .blackjack  (blackjack)
  );

endmodule

// File: tb/tb_card_deal_ctrl.sv
// Scoreboard bench for card_deal_ctrl (default build, REVEAL_FRAMES=2).
// Stimulus pushes expected deal results; a monitor checks each deal_ack
// and the totals one cycle later.
module tb_card_deal_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        deal_req = 1'b0;
  logic        clear = 1'b0;
  logic        card_valid = 1'b0;
  logic [5:0]  card_code = 6'd0;
`ifdef CARD_DEAL_HOLE_EN
  logic        reveal_hole = 1'b0;
`endif
  logic        card_ready, deal_ack, deal_err, busy;
  logic [3:0]  card_count;
  logic [8:0]  slot_visible;
  logic [53:0] slot_cards;
  logic [4:0]  hand_total;
  logic        bust, blackjack;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       err;
    logic [3:0] cnt;
    logic [8:0] vis;
    logic [4:0] tot;
    logic       bust;
    logic       bj;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  card_deal_ctrl #(
    .NUM_SLOTS     (9),
    .REVEAL_FRAMES (2),
    .CNT_W         (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .deal_req     (deal_req),
    .clear        (clear),
    .card_valid   (card_valid),
    .card_code    (card_code),
`ifdef CARD_DEAL_HOLE_EN
    .reveal_hole  (reveal_hole),
`endif
    .card_ready   (card_ready),
    .deal_ack     (deal_ack),
    .deal_err     (deal_err),
    .busy         (busy),
    .card_count   (card_count),
    .slot_visible (slot_visible),
    .slot_cards   (slot_cards),
    .hand_total   (hand_total),
    .bust         (bust),
    .blackjack    (blackjack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: compare each acknowledged deal, then totals one cycle later.
  exp_t cur;
  logic tot_pending = 1'b0;
  always @(negedge clk) begin
    if (tot_pending) begin
      tot_pending = 1'b0;
      chk("hand_total", 64'(hand_total), 64'(cur.tot));
      chk("bust", 64'(bust), 64'(cur.bust));
      chk("blackjack", 64'(blackjack), 64'(cur.bj));
    end
    if (!rst && deal_ack) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got deal_ack=1 required none");
      end else begin
        cur = sb.pop_front();
        chk("deal_err", 64'(deal_err), 64'(cur.err));
        chk("card_count", 64'(card_count), 64'(cur.cnt));
        chk("slot_visible", 64'(slot_visible), 64'(cur.vis));
        tot_pending = 1'b1;
      end
    end
  end

  // One deal: request, offer the card, tick frames until acknowledged.
  task automatic deal(input logic [5:0] code, input logic e_err, input logic [3:0] e_cnt,
                      input logic [8:0] e_vis, input logic [4:0] e_tot, input logic e_bust,
                      input logic e_bj, output int first_ready, output int n_ready);
    exp_t e;
    logic pend;
    logic done;
    e.err = e_err; e.cnt = e_cnt; e.vis = e_vis; e.tot = e_tot; e.bust = e_bust; e.bj = e_bj;
    sb.push_back(e);
    first_ready = -1;
    n_ready = 0;
    pend = 1'b0;
    done = 1'b0;
    deal_req = 1'b1;
    card_valid = 1'b1;
    card_code = code;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (pend) begin
        card_valid = 1'b0;
        pend = 1'b0;
      end
      frame_tick = (c % 3 == 2);
      if (card_ready) begin
        n_ready++;
        if (first_ready < 0) first_ready = c;
        if (card_valid) pend = 1'b1;
      end
      if (deal_ack) begin
        deal_req = 1'b0;
        done = 1'b1;
      end
    end
    frame_tick = 1'b0;
    card_valid = 1'b0;
    deal_req = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL deal_timeout: got no deal_ack required one (code %0d)", code);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int fr, nr;
    logic [53:0] all_aces;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_card_count", 64'(card_count), 64'd0);
    chk("rst_slot_visible", 64'(slot_visible), 64'd0);
    chk("rst_slot_cards", 64'(slot_cards), 64'd0);
    chk("rst_hand_total", 64'(hand_total), 64'd0);
    chk("rst_busy_ready_ack", 64'({busy, card_ready, deal_ack, deal_err}), 64'd0);

    // Ace, king, five
    deal(6'd0, 0, 4'd1, 9'h001, 5'd11, 0, 0, fr, nr);
    chk("first_ready_latency", 64'(fr), 64'd0);
    chk("slot0_code", 64'(slot_cards[5:0]), 64'd0);
    deal(6'd12, 0, 4'd2, 9'h003, 5'd21, 0, 1, fr, nr);
    deal(6'd4,  0, 4'd3, 9'h007, 5'd16, 0, 0, fr, nr);
    do_clear();

    // Jack, queen, four -> bust
    deal(6'd10, 0, 4'd1, 9'h001, 5'd10, 0, 0, fr, nr);
    deal(6'd11, 0, 4'd2, 9'h003, 5'd20, 0, 0, fr, nr);
    deal(6'd3,  0, 4'd3, 9'h007, 5'd24, 1, 0, fr, nr);
    do_clear();
    chk("clear_count", 64'(card_count), 64'd0);

    // Nine aces fill the hand, then a refused tenth request
    for (int k = 1; k <= 9; k++) begin
      deal(6'd13, 0, 4'(k), 9'((1 << k) - 1), 5'(k + 10), 0, 0, fr, nr);
    end
    for (int i = 0; i < 9; i++) all_aces[6*i +: 6] = 6'd13;
    chk("nine_aces_slots", 64'(slot_cards), 64'(all_aces));
    deal(6'd20, 1, 4'd9, 9'h1FF, 5'd19, 0, 0, fr, nr);
    chk("full_no_ready", 64'(nr), 64'd0);
    do_clear();

    // Clear while slot 2 is in its reveal delay
    deal(6'd5, 0, 4'd1, 9'h001, 5'd6,  0, 0, fr, nr);
    deal(6'd6, 0, 4'd2, 9'h003, 5'd13, 0, 0, fr, nr);
    deal_req = 1'b1;
    card_valid = 1'b1;
    card_code = 6'd7;
    for (int c = 0; c < 20 && card_count != 4'd3; c++) begin
      @(posedge clk); #1;
    end
    card_valid = 1'b0;
    deal_req = 1'b0;
    chk("slot2_stored", 64'(slot_cards[17:12]), 64'd7);
    chk("in_reveal_busy", 64'(busy), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_reveal_count", 64'(card_count), 64'd0);
    chk("clr_reveal_visible", 64'(slot_visible), 64'd0);
    chk("clr_reveal_slots", 64'(slot_cards), 64'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      frame_tick = (c % 2 == 0);
    end
    frame_tick = 1'b0;
    deal(6'd8, 0, 4'd1, 9'h001, 5'd9, 0, 0, fr, nr);
    chk("refill_slot0", 64'(slot_cards[5:0]), 64'd8);

    // Out-of-deck code counts as ten and is stored unchanged
    deal(6'd60, 0, 4'd2, 9'h003, 5'd19, 0, 0, fr, nr);
    chk("code60_stored", 64'(slot_cards[11:6]), 64'd60);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
